// File: rtl/osc_clk_supervisor.sv
// Crystal oscillator supervisor: measures the crystal against the RC-derived PCLK,
// qualifies it over consecutive good windows and sequences the clock mux select.
module osc_clk_supervisor #(
    parameter int WINDOW       = 1024,
    parameter int MIN_CNT      = 380,
    parameter int MAX_CNT      = 440,
    parameter int GOOD_WINDOWS = 4,
    parameter int SWITCH_HOLD  = 8
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        xtl_clk_in,
    input  logic        enable,
    input  logic        force_rc,
    output logic        sel_xtl,
    output logic        xtl_good,
    output logic        xtl_fail_irq,
    output logic [15:0] meas_count,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        RC_RUN    = 3'd0,
        QUALIFY   = 3'd1,
        SW_TO_XTL = 3'd2,
        XTL_RUN   = 3'd3,
        SW_TO_RC  = 3'd4,
        FAULT     = 3'd5
    } state_t;

    localparam logic [15:0] WIN_LAST   = 16'(WINDOW - 1);
    localparam logic [15:0] CNT_MIN    = 16'(MIN_CNT);
    localparam logic [15:0] CNT_MAX    = 16'(MAX_CNT);
    localparam logic [3:0]  STREAK_MAX = 4'(GOOD_WINDOWS);
    localparam logic [7:0]  HOLD_LAST  = 8'(SWITCH_HOLD - 1);

    state_t      state_q;
    state_t      state_d;
    logic        sync1;
    logic        sync2;
    logic        sync3;
    logic        xtl_rise;
    logic [15:0] win_cnt;
    logic [15:0] edge_cnt;
    logic [15:0] final_cnt;
    logic [3:0]  streak_q;
    logic [3:0]  streak_d;
    logic [7:0]  hold_cnt;
    logic        win_close;
    logic        win_good;
    logic        bad_close;
    logic        abort;
    logic        hold_done;
    logic        sel_d;
    logic        irq_d;

    assign xtl_rise  = sync2 & ~sync3;
    assign win_close = (win_cnt == WIN_LAST);
    assign final_cnt = (xtl_rise && edge_cnt != 16'hFFFF) ? edge_cnt + 16'd1 : edge_cnt;
    assign win_good  = (final_cnt >= CNT_MIN) && (final_cnt <= CNT_MAX);
    assign bad_close = win_close && !win_good;
    assign abort     = !enable || force_rc;
    assign hold_done = (hold_cnt == HOLD_LAST);
    assign state     = state_q;

    // Measurement runs free in every state; the FSM only observes its close results.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            win_cnt    <= 16'd0;
            edge_cnt   <= 16'd0;
            meas_count <= 16'd0;
            xtl_good   <= 1'b0;
            streak_q   <= 4'd0;
        end else begin
            sync1    <= xtl_clk_in;
            sync2    <= sync1;
            sync3    <= sync2;
            win_cnt  <= win_close ? 16'd0 : win_cnt + 16'd1;
            streak_q <= streak_d;
            if (win_close) begin
                edge_cnt   <= 16'd0;
                meas_count <= final_cnt;
                xtl_good   <= win_good;
            end else begin
                edge_cnt <= final_cnt;
            end
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (win_close) begin
            if (!win_good)
                streak_d = 4'd0;
            else if (streak_q < STREAK_MAX)
                streak_d = streak_q + 4'd1;
        end
    end

    // Hold counter restarts on every state change so each switch state times from entry.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN)
            hold_cnt <= 8'd0;
        else if (state_d != state_q)
            hold_cnt <= 8'd0;
        else if (state_q == SW_TO_XTL || state_q == SW_TO_RC)
            hold_cnt <= hold_cnt + 8'd1;
        else
            hold_cnt <= 8'd0;
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q      <= RC_RUN;
            sel_xtl      <= 1'b0;
            xtl_fail_irq <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_xtl      <= sel_d;
            xtl_fail_irq <= irq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RC_RUN: begin
                if (!abort) state_d = QUALIFY;
            end
            QUALIFY: begin
                if (abort)                        state_d = RC_RUN;
                else if (streak_d == STREAK_MAX)  state_d = SW_TO_XTL;
            end
            SW_TO_XTL: begin
                if (abort)          state_d = RC_RUN;
                else if (bad_close) state_d = QUALIFY;
                else if (hold_done) state_d = XTL_RUN;
            end
            XTL_RUN: begin
                // A failing crystal outranks a voluntary fallback so the fault is reported.
                if (bad_close)  state_d = FAULT;
                else if (abort) state_d = SW_TO_RC;
            end
            SW_TO_RC: begin
                if (hold_done) state_d = RC_RUN;
            end
            FAULT: begin
                if (!enable) state_d = RC_RUN;
            end
            default: state_d = RC_RUN;
        endcase
    end

    // Select and irq are registered from the next state so they change with the state.
    always_comb begin
        sel_d = (state_d == XTL_RUN);
        irq_d = (state_q == XTL_RUN) && (state_d == FAULT);
    end

endmodule

// File: tb/tb_osc_clk_supervisor.sv
// Self-checking bench for osc_clk_supervisor: a window/edge-count model predicts
// every output each cycle, and directed scenarios pin key values by hand.
`timescale 1ns/1ps
module tb_osc_clk_supervisor;

    localparam int WINDOW       = 1024;
    localparam int MIN_CNT      = 380;
    localparam int MAX_CNT      = 440;
    localparam int GOOD_WINDOWS = 4;
    localparam int SWITCH_HOLD  = 8;

    localparam int S_RC = 0, S_QUAL = 1, S_SWX = 2, S_XTL = 3, S_SWR = 4, S_FAULT = 5;

    logic        PCLK = 1'b0;
    logic        PRESETN;
    logic        xtl_clk_in;
    logic        enable;
    logic        force_rc;
    logic        sel_xtl;
    logic        xtl_good;
    logic        xtl_fail_irq;
    logic [15:0] meas_count;
    logic [2:0]  state;

    int check_count = 0;
    int pass_count  = 0;
    bit check_en    = 1'b0;

    realtime xtl_half = 25.0;
    bit      xtl_run  = 1'b1;

    osc_clk_supervisor #(
        .WINDOW(WINDOW), .MIN_CNT(MIN_CNT), .MAX_CNT(MAX_CNT),
        .GOOD_WINDOWS(GOOD_WINDOWS), .SWITCH_HOLD(SWITCH_HOLD)
    ) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .xtl_clk_in(xtl_clk_in),
        .enable(enable), .force_rc(force_rc), .sel_xtl(sel_xtl),
        .xtl_good(xtl_good), .xtl_fail_irq(xtl_fail_irq),
        .meas_count(meas_count), .state(state)
    );

    // 50 MHz PCLK; crystal transitions stay phase-offset from every PCLK edge.
    initial forever #10 PCLK = ~PCLK;

    initial begin
        xtl_clk_in = 1'b0;
        #3;
        forever begin
            #(xtl_half);
            xtl_clk_in = xtl_run ? ~xtl_clk_in : 1'b0;
        end
    end

    // Model: edge E is the E-th PCLK edge since reset release; windows close on E % WINDOW == 0.
    // A crystal rise first sampled at edge k is counted in the window containing cycle k+1.
    int   m_edge    = 0;
    int   m_closes  = 0;
    int   m_streak  = 0;
    int   m_deadline = 0;
    int   m_state   = S_RC;
    bit   m_prev    = 1'b0;
    bit   m_sel     = 1'b0;
    bit   m_irq     = 1'b0;
    bit   m_good    = 1'b0;
    int   m_meas    = 0;
    int   rise_q[$];

    always @(posedge PCLK or negedge PRESETN) begin
        int  cnt;
        bit  closing;
        bit  cl_good;
        bit  abort;
        if (!PRESETN) begin
            m_edge = 0; m_closes = 0; m_streak = 0; m_deadline = 0;
            m_state = S_RC; m_prev = 1'b0; m_sel = 1'b0; m_irq = 1'b0;
            m_good = 1'b0; m_meas = 0;
            rise_q.delete();
        end else begin
            m_edge  = m_edge + 1;
            closing = (m_edge % WINDOW) == 0;
            cl_good = 1'b0;
            if (xtl_clk_in && !m_prev) rise_q.push_back(m_edge);
            m_prev = xtl_clk_in;
            if (closing) begin
                cnt = 0;
                foreach (rise_q[i]) if (rise_q[i] <= m_edge - 2) cnt++;
                while (rise_q.size() > 0 && rise_q[0] < m_edge - 1) void'(rise_q.pop_front());
                if (cnt > 65535) cnt = 65535;
                cl_good  = (cnt >= MIN_CNT) && (cnt <= MAX_CNT);
                m_meas   = cnt;
                m_good   = cl_good;
                m_streak = cl_good ? ((m_streak < GOOD_WINDOWS) ? m_streak + 1 : GOOD_WINDOWS) : 0;
                m_closes = m_closes + 1;
            end
            abort = !enable || force_rc;
            m_irq = 1'b0;
            case (m_state)
                S_RC:    if (!abort) m_state = S_QUAL;
                S_QUAL:  if (abort) m_state = S_RC;
                         else if (m_streak == GOOD_WINDOWS) begin
                             m_state = S_SWX; m_deadline = m_edge + SWITCH_HOLD;
                         end
                S_SWX:   if (abort) m_state = S_RC;
                         else if (closing && !cl_good) m_state = S_QUAL;
                         else if (m_edge == m_deadline) m_state = S_XTL;
                S_XTL:   if (closing && !cl_good) begin
                             m_state = S_FAULT; m_irq = 1'b1;
                         end else if (abort) begin
                             m_state = S_SWR; m_deadline = m_edge + SWITCH_HOLD;
                         end
                S_SWR:   if (m_edge == m_deadline) m_state = S_RC;
                S_FAULT: if (!enable) m_state = S_RC;
                default: m_state = S_RC;
            endcase
            m_sel = (m_state == S_XTL);
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge PCLK) begin
        if (check_en && PRESETN) begin
            check_count++;
            if (state == 3'(m_state) && sel_xtl == m_sel && xtl_fail_irq == m_irq &&
                xtl_good == m_good && meas_count == 16'(m_meas))
                pass_count++;
            else
                $display("[TB] FAIL cycle_compare edge=%0d got st=%0d sel=%0b irq=%0b good=%0b meas=%0d want st=%0d sel=%0b irq=%0b good=%0b meas=%0d",
                         m_edge, state, sel_xtl, xtl_fail_irq, xtl_good, meas_count,
                         m_state, m_sel, m_irq, m_good, m_meas);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) pass_count++;
        else $display("[TB] FAIL %s got=%0d want=%0d", name, actual, expected);
    endtask

    task automatic applyStimulus(input bit en, input bit frc);
        enable   = en;
        force_rc = frc;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic waitClose(input string name);
        int c0 = m_closes;
        int k  = 0;
        while (m_closes == c0 && k < WINDOW + 20) begin
            @(negedge PCLK);
            k++;
        end
        if (m_closes == c0) checkOutput({name, "_timeout"}, 0, 1);
    endtask

    task automatic waitState(input string name, input int target, input int budget);
        int k = 0;
        while (int'(state) != target && k < budget) begin
            @(negedge PCLK);
            k++;
        end
        checkOutput(name, int'(state), target);
    endtask

    task automatic midReset(input string name);
        #3 PRESETN = 1'b0;
        #1;
        checkOutput({name, "_sel_async"}, int'(sel_xtl), 0);
        checkOutput({name, "_state_async"}, int'(state), S_RC);
        waitCycles(3);
        PRESETN = 1'b1;
    endtask

    initial begin
        PRESETN = 1'b0;
        applyStimulus(1'b0, 1'b0);

        // Reset with crystal toggling
        waitCycles(5);
        checkOutput("rst_sel", int'(sel_xtl), 0);
        checkOutput("rst_irq", int'(xtl_fail_irq), 0);
        checkOutput("rst_good", int'(xtl_good), 0);
        checkOutput("rst_meas", int'(meas_count), 0);
        checkOutput("rst_state", int'(state), 0);
        PRESETN  = 1'b1;
        check_en = 1'b1;
        waitCycles(50);
        checkOutput("idle_state", int'(state), S_RC);

        // Qualification at 20 MHz
        applyStimulus(1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            waitClose("qual_close");
            checkOutput("qual_good", int'(xtl_good), 1);
            if (i > 1) checkOutput("qual_meas_409_410", int'(meas_count >= 409 && meas_count <= 410), 1);
            checkOutput("qual_state", int'(state), (i < 4) ? S_QUAL : S_SWX);
        end
        waitCycles(7);
        checkOutput("hold_sel_low", int'(sel_xtl), 0);
        checkOutput("hold_state", int'(state), S_SWX);
        waitCycles(1);
        checkOutput("xtl_sel", int'(sel_xtl), 1);
        checkOutput("xtl_state", int'(state), S_XTL);

        // Crystal loss
        xtl_run = 1'b0;
        waitClose("loss_close");
        checkOutput("loss_meas_low", int'(meas_count < 380), 1);
        checkOutput("loss_state", int'(state), S_FAULT);
        checkOutput("loss_sel", int'(sel_xtl), 0);
        checkOutput("loss_irq", int'(xtl_fail_irq), 1);
        waitCycles(1);
        checkOutput("loss_irq_once", int'(xtl_fail_irq), 0);
        applyStimulus(1'b1, 1'b1);
        waitCycles(5);
        checkOutput("fault_sticky", int'(state), S_FAULT);
        applyStimulus(1'b0, 1'b0);
        waitCycles(1);
        checkOutput("fault_exit", int'(state), S_RC);

        // Out of range at 25 MHz
        xtl_half = 20.0;
        xtl_run  = 1'b1;
        applyStimulus(1'b1, 1'b0);
        waitClose("oor_close0");
        for (int i = 0; i < 2; i++) begin
            waitClose("oor_close");
            checkOutput("oor_meas", int'(meas_count), 512);
            checkOutput("oor_good", int'(xtl_good), 0);
            checkOutput("oor_state", int'(state), S_QUAL);
        end

        // Voluntary fallback
        xtl_half = 25.0;
        waitState("fb_reach_xtl", S_XTL, 7 * WINDOW);
        applyStimulus(1'b1, 1'b1);
        waitCycles(1);
        checkOutput("fb_state", int'(state), S_SWR);
        checkOutput("fb_sel", int'(sel_xtl), 0);
        checkOutput("fb_irq", int'(xtl_fail_irq), 0);
        waitCycles(7);
        checkOutput("fb_hold", int'(state), S_SWR);
        waitCycles(1);
        checkOutput("fb_rc", int'(state), S_RC);

        // Fallback coincident with a bad close
        applyStimulus(1'b0, 1'b0);
        xtl_run = 1'b0;
        waitClose("clr_close1");
        waitClose("clr_close2");
        xtl_run = 1'b1;
        applyStimulus(1'b1, 1'b0);
        waitState("co_reach_xtl", S_XTL, 7 * WINDOW);
        xtl_run = 1'b0;
        for (int k = 0; k < WINDOW + 4 && ((m_edge + 1) % WINDOW) != 0; k++) waitCycles(1);
        applyStimulus(1'b1, 1'b1);
        waitCycles(1);
        checkOutput("co_state", int'(state), S_FAULT);
        checkOutput("co_irq", int'(xtl_fail_irq), 1);
        checkOutput("co_sel", int'(sel_xtl), 0);
        applyStimulus(1'b0, 1'b0);
        waitCycles(1);
        checkOutput("co_rc", int'(state), S_RC);

        // Reset during SW_TO_XTL, then during XTL_RUN
        xtl_run = 1'b1;
        applyStimulus(1'b1, 1'b0);
        waitState("rs_reach_swx", S_SWX, 7 * WINDOW);
        midReset("rs_swx");
        for (int i = 1; i <= 4; i++) begin
            waitClose("rs_close");
            checkOutput("rs_requal_state", int'(state), (i < 4) ? S_QUAL : S_SWX);
        end
        waitState("rs_reach_xtl", S_XTL, 20);
        checkOutput("rs_sel_high", int'(sel_xtl), 1);
        midReset("rs_xtl");
        for (int i = 1; i <= 4; i++) begin
            waitClose("rs2_close");
            checkOutput("rs2_requal_state", int'(state), (i < 4) ? S_QUAL : S_SWX);
        end

        waitCycles(2);
        check_en = 1'b0;
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
